// File: rtl/knn_img_host_if.sv
// knn_img_host_if: pixel stream, knn_top core port and label stream.
// slave is the host controller side, master the system/core side.
interface knn_img_host_if #(
    parameter int ADDR_W  = 10,
    parameter int PIX_W   = 8,
    parameter int RES_W   = 32,
    parameter int LABEL_W = 4
) ();
    logic [PIX_W-1:0]   s_pix_data;
    logic               s_pix_valid;
    logic               s_pix_last;
    logic               s_pix_ready;
    logic               knn_ap_start;
    logic               knn_ap_ready;
    logic               knn_ap_idle;
    logic               knn_ap_done;
    logic [ADDR_W-1:0]  image_r_address0;
    logic [ADDR_W-1:0]  image_r_address1;
    logic               image_r_ce0;
    logic               image_r_ce1;
    logic [PIX_W-1:0]   image_r_q0;
    logic [PIX_W-1:0]   image_r_q1;
    logic [RES_W-1:0]   knn_result;
    logic               knn_result_ap_vld;
    logic [LABEL_W-1:0] m_label;
    logic               m_label_err;
    logic               m_label_valid;
    logic               m_label_ready;
    logic               frame_err;

    modport slave (
        input  s_pix_data, s_pix_valid, s_pix_last,
        output s_pix_ready,
        output knn_ap_start,
        input  knn_ap_ready, knn_ap_idle, knn_ap_done,
        input  image_r_address0, image_r_address1,
        input  image_r_ce0, image_r_ce1,
        output image_r_q0, image_r_q1,
        input  knn_result, knn_result_ap_vld,
        output m_label, m_label_err, m_label_valid,
        input  m_label_ready,
        output frame_err
    );

    modport master (
        output s_pix_data, s_pix_valid, s_pix_last,
        input  s_pix_ready,
        input  knn_ap_start,
        output knn_ap_ready, knn_ap_idle, knn_ap_done,
        output image_r_address0, image_r_address1,
        output image_r_ce0, image_r_ce1,
        input  image_r_q0, image_r_q1,
        output knn_result, knn_result_ap_vld,
        input  m_label, m_label_err, m_label_valid,
        output m_label_ready,
        input  frame_err
    );
endinterface

// File: rtl/knn_img_host.sv
// knn_img_host: ping-pong image buffer and ap_ctrl_hs host for knn_top.
// Serves the core's image_r ports and returns the predicted label.
module knn_img_host #(
    parameter int IMAGE_SIZE = 784,
    parameter int ADDR_W     = 10,
    parameter int PIX_W      = 8,
    parameter int RES_W      = 32,
    parameter int LABEL_W    = 4
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    knn_img_host_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE, S_START, S_RUN, S_DELIVER
    } state_t;

    localparam logic [ADDR_W-1:0] IMG_N    = ADDR_W'(IMAGE_SIZE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMAGE_SIZE - 1);

    state_t             state, state_nx;
    logic               rst_done;
    logic [1:0]         full;
    logic               wr_bank, rd_bank;
    logic [ADDR_W-1:0]  wr_idx;
    logic               res_seen;
    logic [RES_W-1:0]   result;
    logic               frame_err_q;
    logic [PIX_W-1:0]   q0, q1;
    logic [PIX_W-1:0]   mem [2][IMAGE_SIZE];
    logic               pix_acc, frame_end, lbl_acc, label_ok;
    logic               start, lvalid, lerr;
    logic [LABEL_W-1:0] label;

    assign bus.s_pix_ready   = rst_done & ~full[wr_bank];
    assign bus.knn_ap_start  = start;
    assign bus.m_label       = label;
    assign bus.m_label_err   = lerr;
    assign bus.m_label_valid = lvalid;
    assign bus.frame_err     = frame_err_q;
    assign bus.image_r_q0    = q0;
    assign bus.image_r_q1    = q1;

    assign pix_acc   = bus.s_pix_valid & bus.s_pix_ready;
    assign frame_end = pix_acc & (wr_idx == LAST_IDX);
    assign lbl_acc   = (state == S_DELIVER) & bus.m_label_ready;
    assign label_ok  = res_seen & (result <= RES_W'(9));

    // Write side: a short frame is dropped, a long one is still committed.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_done    <= 1'b0;
            full        <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_idx      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (frame_end) begin
                full[wr_bank] <= 1'b1;
                wr_idx        <= '0;
                wr_bank       <= ~wr_bank;
                if (!bus.s_pix_last) frame_err_q <= 1'b1;
            end else if (pix_acc && bus.s_pix_last) begin
                frame_err_q <= 1'b1;
                wr_idx      <= '0;
            end else if (pix_acc) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (lbl_acc) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (pix_acc) mem[wr_bank][wr_idx] <= bus.s_pix_data;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            q0 <= '0;
            q1 <= '0;
        end else begin
            if (bus.image_r_ce0)
                q0 <= (bus.image_r_address0 < IMG_N) ?
                      mem[rd_bank][bus.image_r_address0] : '0;
            if (bus.image_r_ce1)
                q1 <= (bus.image_r_address1 < IMG_N) ?
                      mem[rd_bank][bus.image_r_address1] : '0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= S_IDLE;
            res_seen <= 1'b0;
            result   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_START && bus.knn_ap_ready)
                res_seen <= 1'b0;
            if (state == S_RUN && bus.knn_result_ap_vld) begin
                result   <= bus.knn_result;
                res_seen <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        lvalid   = 1'b0;
        lerr     = 1'b0;
        label    = '0;
        unique case (state)
            S_IDLE:
                if (full[rd_bank] && bus.knn_ap_idle) state_nx = S_START;
            S_START: begin
                start = 1'b1;
                if (bus.knn_ap_ready) state_nx = S_RUN;
            end
            S_RUN:
                if (bus.knn_ap_done) state_nx = S_DELIVER;
            S_DELIVER: begin
                lvalid = 1'b1;
                lerr   = ~label_ok;
                label  = label_ok ? result[LABEL_W-1:0] : '1;
                if (bus.m_label_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule
